ad9361_cmos_tx: RTL

- Dual-port CMOS transmit handler for a single AD9361 in 2T mode; the counterpart of the dual-port RX handler.
- Accepts per-cycle sample pairs for channel 0 and channel 1 through a valid/ready stream and buffers them in a small FIFO.
- Sequences TXNRX/ENABLE (ENSM pulse mode) and emits rise/fall data and frame words that feed external ODDR primitives.
- Sits between the baseband TX datapath and the AD9361 P0/P1 pins.

---
 rtl/ad9361_cmos_tx.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ad9361_cmos_tx.sv
// ad9361_cmos_tx
//   Dual-port CMOS transmit handler for one AD9361 running in 2T mode.
//   Sample pairs for channel 0 and channel 1 arrive on a valid/ready stream
//   and are buffered in a small FIFO. The block sequences TXNRX/ENABLE in
//   ENSM pulse mode and produces rising/falling-edge data and frame words
//   that drive external ODDR primitives on the P0/P1/FB_CLK pins.
//
//   Optional feature macro: AD9361_TX_TEST_TONE_EN
//     When defined, adds input test_mode. While test_mode=1 in RUN, the FIFO
//     is bypassed and a 12-bit ramp (P0) and its complement (P1) are sent.
//
// Ports
//   clk            data clock, all logic on the rising edge
//   reset          synchronous, active-high
//   start          level: 1 = transmit, 0 = return to idle
//   test_mode      (only with AD9361_TX_TEST_TONE_EN) ramp test tone select
//   in_valid       sample pair valid
//   in_ready       FIFO can accept (registered)
//   in_i0/in_q0    channel 0 I/Q
//   in_i1/in_q1    channel 1 I/Q
//   tx_data_p0_r/f P0 (I) word for rising/falling edge
//   tx_data_p1_r/f P1 (Q) word for rising/falling edge
//   tx_frame_r/f   frame word for rising/falling edge
//   txnrx, enable  AD9361 control pins
//   active         high while in RUN
//   underrun_count saturating count of RUN cycles with an empty FIFO
module ad9361_cmos_tx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int STARTUP_DELAY  = 16,
  parameter int ENABLE_CYCLES  = 4,
  parameter int UNDERRUN_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
`ifdef AD9361_TX_TEST_TONE_EN
  input  logic                      test_mode,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [11:0]        in_i0,
  input  logic signed [11:0]        in_q0,
  input  logic signed [11:0]        in_i1,
  input  logic signed [11:0]        in_q1,
  output logic signed [11:0]        tx_data_p0_r,
  output logic signed [11:0]        tx_data_p0_f,
  output logic signed [11:0]        tx_data_p1_r,
  output logic signed [11:0]        tx_data_p1_f,
  output logic                      tx_frame_r,
  output logic                      tx_frame_f,
  output logic                      txnrx,
  output logic                      enable,
  output logic                      active,
  output logic [UNDERRUN_WIDTH-1:0] underrun_count
);

  localparam int DATA_W  = 12;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DLY_MAX = (STARTUP_DELAY > ENABLE_CYCLES) ? STARTUP_DELAY : ENABLE_CYCLES;
  localparam int CNT_W   = $clog2(DLY_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(STARTUP_DELAY - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(ENABLE_CYCLES - 1);
  localparam logic [AW:0]      FULL_CNT   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, SETUP, EN_ON, RUN, EN_OFF, HOLD
  } state_t;

  state_t state, state_n;
  logic [CNT_W-1:0] dly_cnt;

  logic [4*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count, cnt_n;

  logic                push, pop, run_n, ready_n, und_inc;
  logic                vld_p0;
  logic [4*DATA_W-1:0] head_p0;
  logic signed [DATA_W-1:0] p0r_p1, p0f_p1, p1r_p1, p1f_p1;

`ifdef AD9361_TX_TEST_TONE_EN
  logic [DATA_W-1:0] ramp;
`endif

  // Sequencer: IDLE/RUN wait on start, the pulse and hold states are timed.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)                state_n = SETUP;
      SETUP:   if (dly_cnt == SETUP_LAST) state_n = EN_ON;
      EN_ON:   if (dly_cnt == EN_LAST)    state_n = RUN;
      RUN:     if (!start)               state_n = EN_OFF;
      EN_OFF:  if (dly_cnt == EN_LAST)    state_n = HOLD;
      HOLD:    if (dly_cnt == SETUP_LAST) state_n = IDLE;
      default:                           state_n = IDLE;
    endcase
  end

  // Stage p0: FIFO head and next-cycle control, all outputs are computed from
  // state_n so the registered words line up with the active flag.
  always_comb begin
    run_n   = (state_n == RUN);
    vld_p0  = (count != '0);
    head_p0 = mem[rd_ptr];
    push    = in_valid && in_ready;
    pop     = run_n && vld_p0;
`ifdef AD9361_TX_TEST_TONE_EN
    if (test_mode) pop = 1'b0;
`endif
    cnt_n   = count + (AW + 1)'(push) - (AW + 1)'(pop);
    ready_n = ((state_n == SETUP) || (state_n == EN_ON) || run_n) && (cnt_n != FULL_CNT);
`ifdef AD9361_TX_TEST_TONE_EN
    if (run_n && test_mode) ready_n = 1'b0;
`endif

    p0r_p1  = '0;
    p0f_p1  = '0;
    p1r_p1  = '0;
    p1f_p1  = '0;
    und_inc = 1'b0;
    if (run_n) begin
`ifdef AD9361_TX_TEST_TONE_EN
      if (test_mode) begin
        p0r_p1 = ramp;
        p0f_p1 = ramp;
        p1r_p1 = ~ramp;
        p1f_p1 = ~ramp;
      end else
`endif
      if (vld_p0) begin
        // entry layout {i0, q0, i1, q1}: ch0 on the rising edge, ch1 on falling
        p0r_p1 = head_p0[4*DATA_W-1:3*DATA_W];
        p1r_p1 = head_p0[3*DATA_W-1:2*DATA_W];
        p0f_p1 = head_p0[2*DATA_W-1:DATA_W];
        p1f_p1 = head_p0[DATA_W-1:0];
      end else begin
        und_inc = 1'b1;
      end
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the control block.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_i0, in_q0, in_i1, in_q1};
  end

  // Stage p1: registered control and output words.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      dly_cnt        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      in_ready       <= 1'b0;
      txnrx          <= 1'b0;
      enable         <= 1'b0;
      active         <= 1'b0;
      tx_frame_r     <= 1'b0;
      tx_frame_f     <= 1'b0;
      tx_data_p0_r   <= '0;
      tx_data_p0_f   <= '0;
      tx_data_p1_r   <= '0;
      tx_data_p1_f   <= '0;
      underrun_count <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) dly_cnt <= '0;
      else if (state inside {SETUP, EN_ON, EN_OFF, HOLD}) dly_cnt <= dly_cnt + CNT_W'(1);

      // Entering IDLE discards anything left over from the previous burst.
      if (state_n == IDLE) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= cnt_n;
      end

      in_ready     <= ready_n;
      txnrx        <= (state_n != IDLE);
      enable       <= (state_n == EN_ON) || (state_n == EN_OFF);
      active       <= run_n;
      tx_frame_r   <= run_n;
      tx_frame_f   <= 1'b0;
      tx_data_p0_r <= p0r_p1;
      tx_data_p0_f <= p0f_p1;
      tx_data_p1_r <= p1r_p1;
      tx_data_p1_f <= p1f_p1;
      if (und_inc && (underrun_count != '1)) underrun_count <= underrun_count + UNDERRUN_WIDTH'(1);
    end
  end

`ifdef AD9361_TX_TEST_TONE_EN
  // Ramp restarts from 0 on every entry into RUN and wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) ramp <= '0;
    else if (!run_n) ramp <= '0;
    else if (test_mode) ramp <= ramp + DATA_W'(1);
  end
`endif

endmodule
